fpu_dispatch: RTL
=================

# fpu_dispatch

Front-end sequencer for the floating-point unit. Accepts a packed IEEE-754 single-precision request (op, x, y, tag) over a valid/ready handshake and decomposes the operands. It classifies them, computes the adder alignment metadata, and launches exactly one arithmetic unit (`adder`, `multiplier` or `divider`). It then waits for that unit's completion pulse and returns the result with its exception flags over a second valid/ready handshake. It sits directly upstream of the arithmetic units and also consumes their outputs.

## Interface
Parameters:
- `TAG_W`, 4: width of the request tag, returned unchanged with the result.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before the request is aborted; legal range 1..65535.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset, asynchronous assert, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request.
- `op_i`  in  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- `x_i`, `y_i`  in  32  packed operands.
- `tag_i`  in  TAG_W  request tag.
- `resp_valid_o`  out  1  result present.
- `resp_ready_i`  in  1  consumer takes the result.
- `z_o`  out  32  result.
- `tag_o`  out  TAG_W  tag of the result.
- `except_invalid_operation_o`, `except_overflow_o`, `except_timeout_o`  out  1 each  exception flags.
- `add_valid_o`, `mul_valid_o`, `div_valid_o`  out  1 each  one-cycle launch pulses.
- `x_sign_o`, `y_sign_o` (1), `x_exp_o`, `y_exp_o` (8), `x_frac_o`, `y_frac_o` (23)  out  decomposed operand bus shared by all units.
- `x_greater_o`  out  1; `exp_shift_o`  out  8  alignment metadata.
- `x_infinity_o`, `y_infinity_o`, `x_nan_o`, `y_nan_o`  out  1 each  classification flags.
- `{add,mul,div}_valid_i`  in  1 each  unit completion pulses.
- `{add,mul,div}_z_i`  in  32  unit results.
- `{add,mul,div}_invalid_i`, `{add,mul,div}_overflow_i`  in  1 each  unit exception flags.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready_o` = 1.
  - On `req_valid_i`, register op, x, y and tag, then go to ISSUE.
  - For SUB, store y with its sign bit inverted and route it to the adder.
- Decode (combinational, from the registered operands):
  - infinity = exp 255 and frac 0.
  - nan = exp 255 and frac ≠ 0.
  - `x_greater_o` = {x_exp, x_frac} ≥ {y_exp, y_frac}.
  - `exp_shift_o` = |x_exp − y_exp|.
- ISSUE:
  - Pulse exactly one of the unit valid outputs for one cycle, selected by op (ADD/SUB→add, MUL→mul, DIV→div).
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - Operand bus and metadata are held stable.
  - Only the selected unit's completion pulse is honoured; the other units' completion pulses are ignored.
  - On that pulse, latch z and the invalid/overflow flags, set timeout = 0, go to RESP.
  - Otherwise increment the counter. When it reaches `TIMEOUT_CYCLES`, latch z = 0x7FFFFFFF, invalid = 0, overflow = 0, timeout = 1, and go to RESP.
- RESP:
  - `resp_valid_o` = 1.
  - z, tag and the flags are held stable until `resp_ready_i`, then return to IDLE.
- Completion pulses arriving outside WAIT, including late ones after a timeout, are dropped.
- One request in flight at a time; there is no queueing beyond the registered request.
- Reset (asynchronous, any state):
  - State goes to IDLE; all outputs go to 0 except `req_ready_o`, which is 1 once reset is released.
  - Any in-flight request is discarded with no response.

## Timing
- Request accepted at edge N (valid & ready). The launch pulse is high during cycle N+1; WAIT starts at N+2.
- Unit completion pulse sampled at edge M: `resp_valid_o` is high from cycle M+1.
- Overhead: 3 cycles plus unit latency, from acceptance to `resp_valid_o`.
- `req_ready_o` is 0 from N+1 until the cycle after the response handshake completes.
- Minimum spacing between accepted requests is 4 cycles.
- Timeout fires on the `TIMEOUT_CYCLES`-th WAIT cycle without a completion pulse.
- The launch pulse is never longer than one cycle. The divider re-latches while its valid input is high in READY, so a longer pulse would restart it.

## Structure
- Package `fpu_pkg`:
  - `fpu_op_t` enum (ADD, SUB, MUL, DIV).
  - Constants `FPU_INF` = 0x7F800000 and `FPU_NAN` = 0x7FFFFFFF.
  - Function `fpu_classify` (infinity, nan, zero).
- Sub-module `fpu_operand_decode` (combinational): split fields, flags, `x_greater`, `exp_shift`. It is shared with the existing `operands` usage.

## Test plan
- ADD 0x3F800000 + 0x40000000 with a behavioural adder of 2-cycle latency → `z_o` 0x40400000, `add_valid_o` pulsed once, flags 0, tag echoed.
- SUB 0x40400000 − 0x3F800000 → y sign presented as 1 to the adder, `z_o` 0x40000000, `x_greater_o` = 1, `exp_shift_o` = 1.
- DIV 0x7FC00000 / 0x3F800000 → `x_nan_o` = 1, only `div_valid_o` pulses, and the divider's invalid flag propagates to `except_invalid_operation_o`.
- MUL with `resp_ready_i` held 0 for 10 cycles → `resp_valid_o`, `z_o` and tag stable throughout; `req_ready_o` stays 0.
- DIV with no completion pulse and `TIMEOUT_CYCLES` = 8 → after 8 WAIT cycles, `z_o` 0x7FFFFFFF and `except_timeout_o` = 1; a late `div_valid_i` pulse is ignored.
- `rst_i` asserted low mid-WAIT → all outputs 0 immediately, no response ever issued, next request handled normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// FPU dispatch shared types and helpers.
// Op/state encodings, IEEE-754 constants, operand classification.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } fpu_state_t;

  typedef struct packed {
    logic inf;
    logic nan;
    logic zero;
  } fpu_class_t;

  localparam logic [31:0] FPU_INF = 32'h7F80_0000;
  localparam logic [31:0] FPU_NAN = 32'h7FFF_FFFF;

  function automatic fpu_class_t fpu_classify(
    input logic [7:0]  e,
    input logic [22:0] f
  );
    fpu_class_t c;
    c.inf  = (e == 8'hFF) && (f == '0);
    c.nan  = (e == 8'hFF) && (f != '0);
    c.zero = (e == 8'h00) && (f == '0);
    return c;
  endfunction

endpackage

// File: rtl/fpu_dispatch_if.sv
// Request/response handshake bundle of the FPU dispatcher.
// master = requester/consumer, slave = dispatcher.
interface fpu_dispatch_if #(
  parameter int TAG_W = 4
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       op_i;
  logic [31:0]      x_i;
  logic [31:0]      y_i;
  logic [TAG_W-1:0] tag_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [31:0]      z_o;
  logic [TAG_W-1:0] tag_o;
  logic             except_invalid_operation_o;
  logic             except_overflow_o;
  logic             except_timeout_o;

  modport slave (
    input  req_valid_i, op_i, x_i, y_i, tag_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, z_o, tag_o,
    output except_invalid_operation_o,
    output except_overflow_o,
    output except_timeout_o
  );

  modport master (
    output req_valid_i, op_i, x_i, y_i, tag_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, z_o, tag_o,
    input  except_invalid_operation_o,
    input  except_overflow_o,
    input  except_timeout_o
  );
endinterface

// File: rtl/fpu_operand_decode.sv
// Splits two packed singles into fields, classifies them
// and derives the adder alignment metadata.
module fpu_operand_decode
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        x_sign,
  output logic        y_sign,
  output logic [7:0]  x_exp,
  output logic [7:0]  y_exp,
  output logic [22:0] x_frac,
  output logic [22:0] y_frac,
  output logic        x_greater,
  output logic [7:0]  exp_shift,
  output logic        x_infinity,
  output logic        y_infinity,
  output logic        x_nan,
  output logic        y_nan
);

  fpu_class_t cx;
  fpu_class_t cy;
  logic       unused_zero;

  assign x_sign = x[31];
  assign y_sign = y[31];
  assign x_exp  = x[30:23];
  assign y_exp  = y[30:23];
  assign x_frac = x[22:0];
  assign y_frac = y[22:0];

  assign cx = fpu_classify(x_exp, x_frac);
  assign cy = fpu_classify(y_exp, y_frac);

  assign x_infinity  = cx.inf;
  assign y_infinity  = cy.inf;
  assign x_nan       = cx.nan;
  assign y_nan       = cy.nan;
  assign unused_zero = cx.zero ^ cy.zero;

  assign x_greater = {x_exp, x_frac} >= {y_exp, y_frac};
  assign exp_shift = (x_exp >= y_exp) ? x_exp - y_exp
                                      : y_exp - x_exp;

endmodule

// File: rtl/fpu_dispatch.sv
// FPU front-end: accepts one request, launches one unit,
// waits for completion or timeout, returns the result.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fpu_dispatch_if.slave bus,
  output logic        add_valid_o,
  output logic        mul_valid_o,
  output logic        div_valid_o,
  output logic        x_sign_o,
  output logic        y_sign_o,
  output logic [7:0]  x_exp_o,
  output logic [7:0]  y_exp_o,
  output logic [22:0] x_frac_o,
  output logic [22:0] y_frac_o,
  output logic        x_greater_o,
  output logic [7:0]  exp_shift_o,
  output logic        x_infinity_o,
  output logic        y_infinity_o,
  output logic        x_nan_o,
  output logic        y_nan_o,
  input  logic        add_valid_i,
  input  logic        mul_valid_i,
  input  logic        div_valid_i,
  input  logic [31:0] add_z_i,
  input  logic [31:0] mul_z_i,
  input  logic [31:0] div_z_i,
  input  logic        add_invalid_i,
  input  logic        mul_invalid_i,
  input  logic        div_invalid_i,
  input  logic        add_overflow_i,
  input  logic        mul_overflow_i,
  input  logic        div_overflow_i
);

  localparam logic [15:0] TO_LIM = TIMEOUT_CYCLES[15:0];

  fpu_state_t       state_q, state_d;
  fpu_op_t          op_q, op_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      z_q, z_d;
  logic             inv_q, inv_d;
  logic             ovf_q, ovf_d;
  logic             to_q, to_d;

  logic        sel_add, sel_mul, sel_div;
  logic        done;
  logic [31:0] unit_z;
  logic        unit_inv, unit_ovf;
  logic [15:0] cnt_inc;
  logic        busy, issue;

  logic        d_x_sign, d_y_sign;
  logic [7:0]  d_x_exp, d_y_exp;
  logic [22:0] d_x_frac, d_y_frac;
  logic        d_x_greater;
  logic [7:0]  d_exp_shift;
  logic        d_x_inf, d_y_inf, d_x_nan, d_y_nan;

  fpu_operand_decode u_decode (
    .x          (x_q),
    .y          (y_q),
    .x_sign     (d_x_sign),
    .y_sign     (d_y_sign),
    .x_exp      (d_x_exp),
    .y_exp      (d_y_exp),
    .x_frac     (d_x_frac),
    .y_frac     (d_y_frac),
    .x_greater  (d_x_greater),
    .exp_shift  (d_exp_shift),
    .x_infinity (d_x_inf),
    .y_infinity (d_y_inf),
    .x_nan      (d_x_nan),
    .y_nan      (d_y_nan)
  );

  assign sel_add = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign sel_mul = (op_q == OP_MUL);
  assign sel_div = (op_q == OP_DIV);
  assign cnt_inc = cnt_q + 16'd1;

  // Route only the selected unit's completion and result.
  always_comb begin
    done     = 1'b0;
    unit_z   = '0;
    unit_inv = 1'b0;
    unit_ovf = 1'b0;
    unique case (1'b1)
      sel_add: begin
        done     = add_valid_i;
        unit_z   = add_z_i;
        unit_inv = add_invalid_i;
        unit_ovf = add_overflow_i;
      end
      sel_mul: begin
        done     = mul_valid_i;
        unit_z   = mul_z_i;
        unit_inv = mul_invalid_i;
        unit_ovf = mul_overflow_i;
      end
      sel_div: begin
        done     = div_valid_i;
        unit_z   = div_z_i;
        unit_inv = div_invalid_i;
        unit_ovf = div_overflow_i;
      end
      default: ;
    endcase
  end

  // Next state and next register contents.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          op_d    = fpu_op_t'(bus.op_i);
          x_d     = bus.x_i;
          y_d     = bus.y_i;
          if (fpu_op_t'(bus.op_i) == OP_SUB)
            y_d[31] = ~bus.y_i[31];
          tag_d   = bus.tag_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          z_d     = unit_z;
          inv_d   = unit_inv;
          ovf_d   = unit_ovf;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_inc == TO_LIM) begin
          z_d     = FPU_NAN;
          inv_d   = 1'b0;
          ovf_d   = 1'b0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      x_q     <= '0;
      y_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign issue = (state_q == ST_ISSUE);

  assign bus.req_ready_o  = rst_i && (state_q == ST_IDLE);
  assign bus.resp_valid_o = (state_q == ST_RESP);
  assign bus.z_o          = z_q;
  assign bus.tag_o        = tag_q;
  assign bus.except_invalid_operation_o = inv_q;
  assign bus.except_overflow_o          = ovf_q;
  assign bus.except_timeout_o           = to_q;

  assign add_valid_o = issue && sel_add;
  assign mul_valid_o = issue && sel_mul;
  assign div_valid_o = issue && sel_div;

  // Operand bus is quiet while idle so reset leaves it at zero.
  assign x_sign_o     = busy && d_x_sign;
  assign y_sign_o     = busy && d_y_sign;
  assign x_exp_o      = busy ? d_x_exp : '0;
  assign y_exp_o      = busy ? d_y_exp : '0;
  assign x_frac_o     = busy ? d_x_frac : '0;
  assign y_frac_o     = busy ? d_y_frac : '0;
  assign x_greater_o  = busy && d_x_greater;
  assign exp_shift_o  = busy ? d_exp_shift : '0;
  assign x_infinity_o = busy && d_x_inf;
  assign y_infinity_o = busy && d_y_inf;
  assign x_nan_o      = busy && d_x_nan;
  assign y_nan_o      = busy && d_y_nan;

endmodule
